// File: rtl/pixel_tx_sequencer.sv
// Pixel transmit sequencer: buffers processed pixels
// and hands them one by one to a UART transmitter.
module pixel_tx_sequencer #(
  parameter int NUM_PIX    = 10000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        fifo_full,
  output logic        overflow,
  output logic [13:0] tx_count,
  output logic        frame_done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] OCC_FULL = CW'(FIFO_DEPTH);
  localparam logic [13:0] CNT_LAST = 14'(NUM_PIX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_e;

  state_e state_q, state_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic [13:0]   cnt_q, cnt_d;
  logic          fd_q, fd_d;

  logic full_now;
  logic pop;
  logic push;
  logic done;

  // Handshake decode: pop only from IDLE; a pop frees room for a push
  always_comb begin
    full_now = (occ_q == OCC_FULL);
    pop      = (state_q == S_IDLE) && (occ_q != '0) && !tx_busy;
    push     = pix_valid && (!full_now || pop);
    done     = (state_q == S_WAIT_DONE) && !tx_busy;
  end

  // FIFO bookkeeping: pointers, occupancy, full and overflow flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
    if (pix_valid && !push) begin
      ovf_d = 1'b1;
    end
    full_d = (occ_d == OCC_FULL);
  end

  // Transmit FSM next state and held output byte
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_START;
      S_START: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Completed-pixel counter wraps at the frame size
  always_comb begin
    cnt_d = cnt_q;
    fd_d  = 1'b0;
    if (done) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        fd_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 14'd1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      tx_data_q <= '0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      tx_data_q <= tx_data_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      fd_q      <= fd_d;
    end
  end

  // Pixel storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= pix_in;
    end
  end

  // Output mapping
  always_comb begin
    tx_data    = tx_data_q;
    tx_start   = (state_q == S_START);
    fifo_full  = full_q;
    overflow   = ovf_q;
    tx_count   = cnt_q;
    frame_done = fd_q;
  end

endmodule

// File: doc/pixel_tx_sequencer.md
PIXEL_TX_SEQUENCER -- requirements
Module: pixel_tx_sequencer

Interface
REQ-001 SHALL have parameter NUM_PIX, default 10000, meaning pixels per frame returned to MATLAB (100x100 image).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning power-of-two depth of the pixel buffer.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port pix_in, input, 8, processed pixel from the window engine.
REQ-006 SHALL have port pix_valid, input, 1, one-cycle strobe qualifying pix_in.
REQ-007 SHALL have port tx_busy, input, 1, UART transmitter busy flag; high while a byte is shifting out.
REQ-008 SHALL have port tx_data, output, 8, byte presented to the UART transmitter.
REQ-009 SHALL have port tx_start, output, 1, one-cycle request to the UART transmitter to send tx_data.
REQ-010 SHALL have port fifo_full, output, 1, buffer holds FIFO_DEPTH entries.
REQ-011 SHALL have port overflow, output, 1, sticky flag: a pixel was dropped.
REQ-012 SHALL have port tx_count, output, 14, pixels fully transmitted in the current frame.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse when pixel NUM_PIX of a frame completes.

Function
REQ-014 SHALL buffer pixels in a FIFO with occupancy counter 0..FIFO_DEPTH; fifo_full SHALL be a registered copy of (occupancy == FIFO_DEPTH).
REQ-015 SHALL push pix_in when pix_valid=1 and the FIFO is not full; a push when full SHALL drop the pixel and set overflow in the following cycle.
REQ-016 SHALL process a push and a pop in the same cycle with both taking effect and occupancy unchanged; this includes a push while full with a simultaneous pop, which is accepted.
REQ-017 SHALL implement the states IDLE, LOAD, START, WAIT_BUSY and WAIT_DONE.
REQ-018 SHALL, in IDLE with FIFO non-empty and tx_busy=0, pop the head entry into tx_data and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-019 SHALL go from LOAD to START unconditionally, with tx_data stable.
REQ-020 SHALL drive tx_start=1 for exactly the one cycle spent in START, then go to WAIT_BUSY.
REQ-021 SHALL hold tx_data stable from LOAD until return to IDLE.
REQ-022 SHALL stay in WAIT_BUSY until tx_busy=1, then go to WAIT_DONE; tx_start SHALL NOT be re-issued.
REQ-023 SHALL, in WAIT_DONE when tx_busy=0, go to IDLE and increment tx_count.
REQ-024 SHALL, if tx_count == NUM_PIX-1 at that completion, wrap tx_count to 0 and pulse frame_done for one cycle aligned with the wrap.
REQ-025 SHALL give first-pixel latency of pix_valid to tx_start of 3 cycles: push, then IDLE pop, then LOAD, with tx_start high in the third cycle after pix_valid.
REQ-026 SHALL keep the FIFO pointers at log2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH.
REQ-027 SHALL have tx_count wrap only at NUM_PIX, never at 2^14.
REQ-028 SHALL NOT issue a pop while the FSM is outside IDLE.

Reset
REQ-029 SHALL, when reset=1 at a clock edge, return the FSM to IDLE and empty the FIFO.
REQ-030 SHALL reset outputs as follows: tx_data=0, tx_start=0, fifo_full=0, overflow=0, tx_count=0, frame_done=0.
REQ-031 SHALL, on reset mid-transmission in any state, abandon the byte in flight without counting it; the first post-reset pop SHALL wait for tx_busy=0 per REQ-018.
REQ-032 SHALL give reset priority over pix_valid, so a pixel strobed during reset is discarded.

Verification
REQ-033 SHALL cover single pixel: pix_in=8'hA5 with one-cycle pix_valid, tx_busy modelled as 10 cycles high starting 1 cycle after tx_start -> tx_start high exactly 3 cycles after pix_valid, tx_data=A5, tx_count=1 after tx_busy falls.
REQ-034 SHALL cover a burst of 20 pixels 0x00..0x13 on consecutive cycles with FIFO_DEPTH=16 -> fifo_full asserts, overflow sets, bytes transmitted in order are exactly the accepted ones, all dropped bytes are the last ones, and no duplicates.
REQ-035 SHALL cover a frame with NUM_PIX=10000 streamed at one pixel per 12 cycles -> frame_done pulses exactly once, tx_count reads 0 afterwards, and output order matches input.
REQ-036 SHALL cover simultaneous events: push on the same cycle as an IDLE pop with the FIFO at 1 entry -> occupancy stays 1, and both bytes are transmitted in order.
REQ-037 SHALL cover reset asserted in WAIT_DONE with 5 pixels queued -> all outputs take reset values next cycle, tx_count=0, and no further tx_start without new pix_valid.
REQ-038 SHALL cover tx_busy held high at the start -> the FSM stays in IDLE with no tx_start until tx_busy=0.
